// File: rtl/paddle_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : paddle_pkg
//  Description : Shared types and constants for paddle_position_accumulator.
//                Holds the quadrature decoder state encoding, the phase
//                constants, the detent threshold and the default bounds.
//  Revision    : 1.0  initial release
// ============================================================================
package paddle_pkg;

  // Decoder state. UNPRIMED waits for the synchroniser to hold a real pin
  // sample before it is trusted as the reference phase.
  typedef enum logic [0:0] {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } dec_state_t;

  // Phase encoding is {A, B}.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Quadrature transitions per detent.
  localparam int SUB_THRESH = 4;

  // Default configuration.
  localparam int DEFAULT_CHANNELS  = 2;
  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_STEP      = 15;
  localparam int DEFAULT_MIN_POS   = 0;
  localparam int DEFAULT_MAX_POS   = 625;
  localparam int DEFAULT_RESET_POS = 312;

  // Next phase in the clockwise sequence 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] cw_next(input logic [1:0] ph);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage : paddle_pkg
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : quad_decoder
//  Description : One rotary encoder channel. Two-flop synchroniser on the
//                A/B pins, priming of the reference phase, 3-bit signed
//                sub-count of quadrature transitions, full-detent step
//                detection and illegal-transition flagging.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   system clock
//    reset_n    in   asynchronous active-low reset
//    rot_a      in   encoder phase A (asynchronous)
//    rot_b      in   encoder phase B (asynchronous)
//    step_up    out  combinational, one full CW detent completed this cycle
//    step_down  out  combinational, one full CCW detent completed this cycle
//    illegal    out  registered one-cycle pulse, both phase bits changed
// ============================================================================
module quad_decoder
  import paddle_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic rot_a,
  input  logic rot_b,
  output logic step_up,
  output logic step_down,
  output logic illegal
);

  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  // Tracks how far real pin data has travelled through the synchroniser, so
  // the reset value 00 of the flops is never taken as a reference phase.
  logic [1:0] fill_q;

  dec_state_t state_q;
  dec_state_t state_n;
  logic [1:0] prev_q;
  logic [1:0] prev_n;
  logic [2:0] sub_q;      // two's complement, -3..+3 at rest
  logic [2:0] sub_n;
  logic       illegal_q;
  logic       illegal_n;
  logic [3:0] delta;
  logic [3:0] sum;

  localparam logic [3:0] SUB_UP = 4'(SUB_THRESH);
  localparam logic [3:0] SUB_DN = 4'(-SUB_THRESH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= PH_00;
      sync2_q <= PH_00;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= {rot_a, rot_b};
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= UNPRIMED;
      prev_q    <= PH_00;
      sub_q     <= 3'b000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      prev_q    <= prev_n;
      sub_q     <= sub_n;
      illegal_q <= illegal_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    prev_n    = prev_q;
    sub_n     = sub_q;
    illegal_n = 1'b0;
    step_up   = 1'b0;
    step_down = 1'b0;
    delta     = 4'b0000;
    sum       = 4'b0000;

    case (state_q)
      UNPRIMED: begin
        if (fill_q[1]) begin
          prev_n  = sync2_q;
          state_n = TRACK;
        end
      end
      TRACK: begin
        if (sync2_q != prev_q) begin
          prev_n = sync2_q;
          if (sync2_q == cw_next(prev_q)) begin
            delta = 4'b0001;
          end else if (prev_q == cw_next(sync2_q)) begin
            delta = 4'b1111;
          end else begin
            illegal_n = 1'b1;
            sub_n     = 3'b000;
          end
          if (delta != 4'b0000) begin
            sum = {sub_q[2], sub_q} + delta;
            if (sum == SUB_UP) begin
              step_up = 1'b1;
              sub_n   = 3'b000;
            end else if (sum == SUB_DN) begin
              step_down = 1'b1;
              sub_n     = 3'b000;
            end else begin
              sub_n = sum[2:0];
            end
          end
        end
      end
      default: state_n = UNPRIMED;
    endcase
  end

  assign illegal = illegal_q;

endmodule : quad_decoder
`default_nettype wire

// File: rtl/paddle_position_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_position_accumulator
//  Description : Per-player bounded paddle positions driven by rotary
//                encoders and inc/dec/load requests. Each channel has its own
//                quad_decoder; this level arbitrates requests and applies the
//                step with saturation, or wrap-around when POSITION_WRAP_EN is
//                defined.
//  Revision    : 1.0  initial release
//
//  Configuration macro
//    POSITION_WRAP_EN  defined: over/underflow wraps within [MIN_POS, MAX_POS]
//                      undefined: over/underflow saturates at the bound
//
//  Ports
//    clk        in   system clock
//    reset_n    in   asynchronous active-low reset
//    rotA       in   [CHANNELS]        encoder phase A per channel
//    rotB       in   [CHANNELS]        encoder phase B per channel
//    inc        in   [CHANNELS]        single-step increase request
//    dec        in   [CHANNELS]        single-step decrease request
//    load       in   [CHANNELS]        load loadValue into channel
//    loadValue  in   [WIDTH]           shared load value (clamped)
//    position   out  [CHANNELS*WIDTH]  channel c at [c*WIDTH +: WIDTH]
//    moved      out  [CHANNELS]        pulse, position changed
//    atLimit    out  [CHANNELS]        level, position at MIN_POS or MAX_POS
//    illegal    out  [CHANNELS]        pulse, illegal quadrature transition
// ============================================================================
module paddle_position_accumulator
  import paddle_pkg::*;
#(
  parameter int CHANNELS  = DEFAULT_CHANNELS,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int STEP      = DEFAULT_STEP,
  parameter int MIN_POS   = DEFAULT_MIN_POS,
  parameter int MAX_POS   = DEFAULT_MAX_POS,
  parameter int RESET_POS = DEFAULT_RESET_POS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       rotA,
  input  logic [CHANNELS-1:0]       rotB,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH-1:0]          loadValue,
  output logic [CHANNELS*WIDTH-1:0] position,
  output logic [CHANNELS-1:0]       moved,
  output logic [CHANNELS-1:0]       atLimit,
  output logic [CHANNELS-1:0]       illegal
);

  // One extra bit so pos + STEP can never overflow before the bound test.
  localparam logic [WIDTH:0]   MIN_W   = (WIDTH+1)'(MIN_POS);
  localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_POS);
  localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   ONE_W   = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_POS);
  localparam logic             RESET_LIM = (RESET_POS == MIN_POS) || (RESET_POS == MAX_POS);

  function automatic logic [WIDTH-1:0] pos_up(input logic [WIDTH-1:0] p);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] res;
    sum = {1'b0, p} + STEP_W;
    res = sum;
`ifdef POSITION_WRAP_EN
    if (sum > MAX_W) res = MIN_W + (sum - MAX_W - ONE_W);
`else
    if (sum > MAX_W) res = MAX_W;
`endif
    return WIDTH'(res);
  endfunction

  function automatic logic [WIDTH-1:0] pos_down(input logic [WIDTH-1:0] p);
    logic [WIDTH:0] ext;
    logic [WIDTH:0] res;
    ext = {1'b0, p};
    if (ext < MIN_W + STEP_W) begin
`ifdef POSITION_WRAP_EN
      res = MAX_W - (MIN_W + STEP_W - ext - ONE_W);
`else
      res = MIN_W;
`endif
    end else begin
      res = ext - STEP_W;
    end
    return WIDTH'(res);
  endfunction

  function automatic logic [WIDTH-1:0] pos_clamp(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    logic [WIDTH:0] res;
    ext = {1'b0, v};
    if (ext < MIN_W)      res = MIN_W;
    else if (ext > MAX_W) res = MAX_W;
    else                  res = ext;
    return WIDTH'(res);
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic             step_up;
    logic             step_down;
    logic [WIDTH-1:0] pos_q;
    logic [WIDTH-1:0] pos_n;
    logic             moved_q;
    logic             lim_q;

    quad_decoder u_dec (
      .clk       (clk),
      .reset_n   (reset_n),
      .rot_a     (rotA[c]),
      .rot_b     (rotB[c]),
      .step_up   (step_up),
      .step_down (step_down),
      .illegal   (illegal[c])
    );

    // Priority: load, then encoder detent, then inc/dec. Conflicting
    // inc and dec cancel out.
    always_comb begin
      pos_n = pos_q;
      if (load[c]) begin
        pos_n = pos_clamp(loadValue);
      end else if (step_up) begin
        pos_n = pos_up(pos_q);
      end else if (step_down) begin
        pos_n = pos_down(pos_q);
      end else if (inc[c] && !dec[c]) begin
        pos_n = pos_up(pos_q);
      end else if (dec[c] && !inc[c]) begin
        pos_n = pos_down(pos_q);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pos_q   <= RESET_V;
        moved_q <= 1'b0;
        lim_q   <= RESET_LIM;
      end else begin
        pos_q   <= pos_n;
        moved_q <= (pos_n != pos_q);
        lim_q   <= ({1'b0, pos_n} == MIN_W) || ({1'b0, pos_n} == MAX_W);
      end
    end

    assign position[c*WIDTH +: WIDTH] = pos_q;
    assign moved[c]                   = moved_q;
    assign atLimit[c]                 = lim_q;
  end

endmodule : paddle_position_accumulator
`default_nettype wire

// File: tb/tb_paddle_position_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paddle_position_accumulator
//  Description : Self-checking bench for paddle_position_accumulator with
//                default parameters. Synchronous requests are checked from a
//                vector table; encoder behaviour through short sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_paddle_position_accumulator;

  logic        clk;
  logic        reset_n;
  logic [1:0]  rotA;
  logic [1:0]  rotB;
  logic [1:0]  inc;
  logic [1:0]  dec;
  logic [1:0]  load;
  logic [15:0] loadValue;
  logic [31:0] position;
  logic [1:0]  moved;
  logic [1:0]  atLimit;
  logic [1:0]  illegal;

  int vectors;
  int miscompares;
  int mv0_cnt, mv1_cnt, il0_cnt, il1_cnt, mv0_at;

  paddle_position_accumulator dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rotA      (rotA),
    .rotB      (rotB),
    .inc       (inc),
    .dec       (dec),
    .load      (load),
    .loadValue (loadValue),
    .position  (position),
    .moved     (moved),
    .atLimit   (atLimit),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  inc;
    logic [1:0]  dec;
    logic [1:0]  load;
    logic [15:0] lv;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic [1:0]  emov;
    logic [1:0]  elim;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  function automatic logic [15:0] pos_of(input int ch);
    return position[ch*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    mv0_cnt = 0; mv1_cnt = 0; il0_cnt = 0; il1_cnt = 0; mv0_at = -1;
  endtask

  // Drive a phase on one channel and hold it for n cycles, tallying pulses.
  task automatic hold_phase(input int ch, input logic [1:0] ph, input int n);
    rotA[ch] = ph[1];
    rotB[ch] = ph[0];
    for (int i = 0; i < n; i++) begin
      tick();
      if (moved[0]) begin mv0_cnt++; mv0_at = i; end
      if (moved[1]) mv1_cnt++;
      if (illegal[0]) il0_cnt++;
      if (illegal[1]) il1_cnt++;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    clear_counts();
    reset_n = 1'b0; rotA = 2'b01; rotB = 2'b01;
    inc = '0; dec = '0; load = '0; loadValue = '0;

    // Vector table: each applied for exactly one edge.
    //          inc    dec    load   lv     p0/p1 (sat | wrap)             mov    lim
    vt[0]  = '{2'b00, 2'b00, 2'b01, 16'd620, 16'd620, 16'd312, 2'b01, 2'b00};
`ifdef POSITION_WRAP_EN
    vt[1]  = '{2'b01, 2'b00, 2'b00, 16'd0,   16'd9,   16'd312, 2'b01, 2'b00};
    vt[2]  = '{2'b01, 2'b00, 2'b00, 16'd0,   16'd24,  16'd312, 2'b01, 2'b00};
    vt[3]  = '{2'b10, 2'b10, 2'b00, 16'd0,   16'd24,  16'd312, 2'b00, 2'b00};
`else
    vt[1]  = '{2'b01, 2'b00, 2'b00, 16'd0,   16'd625, 16'd312, 2'b01, 2'b01};
    vt[2]  = '{2'b01, 2'b00, 2'b00, 16'd0,   16'd625, 16'd312, 2'b00, 2'b01};
    vt[3]  = '{2'b10, 2'b10, 2'b00, 16'd0,   16'd625, 16'd312, 2'b00, 2'b01};
`endif
    vt[4]  = '{2'b00, 2'b10, 2'b01, 16'd10,  16'd10,  16'd297, 2'b11, 2'b00};
`ifdef POSITION_WRAP_EN
    vt[5]  = '{2'b00, 2'b01, 2'b00, 16'd0,   16'd621, 16'd297, 2'b01, 2'b00};
    vt[6]  = '{2'b00, 2'b00, 2'b10, 16'd700, 16'd621, 16'd625, 2'b10, 2'b10};
    vt[7]  = '{2'b00, 2'b00, 2'b11, 16'd0,   16'd0,   16'd0,   2'b11, 2'b11};
    vt[8]  = '{2'b00, 2'b10, 2'b00, 16'd0,   16'd0,   16'd611, 2'b10, 2'b01};
    vt[9]  = '{2'b01, 2'b01, 2'b00, 16'd0,   16'd0,   16'd611, 2'b00, 2'b01};
`else
    vt[5]  = '{2'b00, 2'b01, 2'b00, 16'd0,   16'd0,   16'd297, 2'b01, 2'b01};
    vt[6]  = '{2'b00, 2'b00, 2'b10, 16'd700, 16'd0,   16'd625, 2'b10, 2'b11};
    vt[7]  = '{2'b00, 2'b00, 2'b11, 16'd0,   16'd0,   16'd0,   2'b10, 2'b11};
    vt[8]  = '{2'b00, 2'b10, 2'b00, 16'd0,   16'd0,   16'd0,   2'b00, 2'b11};
    vt[9]  = '{2'b01, 2'b01, 2'b00, 16'd0,   16'd0,   16'd0,   2'b00, 2'b11};
`endif
    vt[10] = '{2'b00, 2'b00, 2'b11, 16'd625, 16'd625, 16'd625, 2'b11, 2'b11};
    vt[11] = '{2'b00, 2'b00, 2'b01, 16'd200, 16'd200, 16'd625, 2'b01, 2'b10};
    vt[12] = '{2'b00, 2'b00, 2'b00, 16'd0,   16'd200, 16'd625, 2'b00, 2'b10};

    // Reset with channel 0 resting at 11: priming must not flag illegal.
    repeat (3) tick();
    check("reset_pos0", pos_of(0), 312);
    check("reset_pos1", pos_of(1), 312);
    reset_n = 1'b1;
    clear_counts();
    hold_phase(0, 2'b11, 6);
    check("prime_illegal0", il0_cnt, 0);
    check("prime_moved0", mv0_cnt, 0);
    check("prime_pos0", pos_of(0), 312);
    check("prime_atlimit", atLimit, 2'b00);

    // Re-reset at phase 00 to start a clean detent.
    reset_n = 1'b0; rotA = 2'b00; rotB = 2'b00;
    tick();
    reset_n = 1'b1;
    hold_phase(0, 2'b00, 6);

    // One CW detent on channel 0.
    clear_counts();
    hold_phase(0, 2'b01, 4);
    hold_phase(0, 2'b11, 4);
    hold_phase(0, 2'b10, 4);
    hold_phase(0, 2'b00, 4);
    check("detent_pos0", pos_of(0), 327);
    check("detent_moved0_cnt", mv0_cnt, 1);
    check("detent_latency", mv0_at, 2);
    check("detent_pos1", pos_of(1), 312);
    check("detent_moved1_cnt", mv1_cnt, 0);

    // Synchronous request table.
    for (int i = 0; i < NV; i++) begin
      inc = vt[i].inc; dec = vt[i].dec; load = vt[i].load; loadValue = vt[i].lv;
      tick();
      check($sformatf("vec%0d_pos0", i), pos_of(0), vt[i].exp0);
      check($sformatf("vec%0d_pos1", i), pos_of(1), vt[i].exp1);
      check($sformatf("vec%0d_moved", i), moved, vt[i].emov);
      check($sformatf("vec%0d_atlimit", i), atLimit, vt[i].elim);
    end
    inc = '0; dec = '0; load = '0; loadValue = '0;

    // Load, inc and encoder step all on the same edge: load wins.
    hold_phase(0, 2'b01, 4);
    hold_phase(0, 2'b11, 4);
    hold_phase(0, 2'b10, 4);
    hold_phase(0, 2'b00, 2);
    load = 2'b01; loadValue = 16'd100; inc = 2'b01;
    tick();
    check("prio_load_pos0", pos_of(0), 100);
    load = '0; inc = '0; loadValue = '0;

    // Encoder step and inc on the same edge: only one step applies.
    hold_phase(0, 2'b01, 4);
    hold_phase(0, 2'b11, 4);
    hold_phase(0, 2'b10, 4);
    hold_phase(0, 2'b00, 2);
    inc = 2'b01;
    tick();
    check("prio_step_pos0", pos_of(0), 115);
    inc = '0;
    tick();
    check("prio_step_hold_pos0", pos_of(0), 115);

    // Illegal jump after one CW transition; sub-count must restart.
    clear_counts();
    hold_phase(0, 2'b01, 4);
    hold_phase(0, 2'b10, 4);
    check("illegal_cnt", il0_cnt, 1);
    check("illegal_moved", mv0_cnt, 0);
    clear_counts();
    hold_phase(0, 2'b00, 4);
    hold_phase(0, 2'b01, 4);
    hold_phase(0, 2'b11, 4);
    check("after_illegal_3trans_moved", mv0_cnt, 0);
    check("after_illegal_3trans_pos", pos_of(0), 115);
    hold_phase(0, 2'b10, 4);
    check("after_illegal_4th_pos", pos_of(0), 130);
    check("after_illegal_illegal_cnt", il0_cnt, 0);

    // Reset mid-detent after two CW transitions.
    hold_phase(0, 2'b00, 4);
    hold_phase(0, 2'b01, 4);
    reset_n = 1'b0;
    #1;
    check("async_reset_pos0", pos_of(0), 312);
    check("async_reset_moved", moved, 2'b00);
    tick();
    tick();
    reset_n = 1'b1;
    hold_phase(0, 2'b01, 6);
    clear_counts();
    hold_phase(0, 2'b11, 4);
    hold_phase(0, 2'b10, 4);
    hold_phase(0, 2'b00, 4);
    check("postreset_3trans_pos0", pos_of(0), 312);
    hold_phase(0, 2'b01, 4);
    check("postreset_detent_pos0", pos_of(0), 327);
    check("postreset_moved_cnt", mv0_cnt, 1);
    check("postreset_pos1", pos_of(1), 312);
    check("postreset_illegal", il0_cnt + il1_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_paddle_position_accumulator
`default_nettype wire
